// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the ccff chain loader: FSM state encoding and
// the default bitstream word width.
`timescale 1ns/1ps

package ccff_loader_pkg;

    localparam int DEF_WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

endpackage

// File: rtl/ccff_rb_collector.sv
// Readback collector: gathers bits coming out of the chain tail MSB first
// and emits a word when it is full, or early (zero padded in the LSBs)
// when the final chain bit has been sampled.
`timescale 1ns/1ps

module ccff_rb_collector
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              sample_i,
    input  logic              bit_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] rb_data_o,
    output logic              rb_valid_o
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] col_q, col_d, col_ins;
    logic [CNT_W-1:0]  cnt_q, cnt_d, idx;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;
    logic              word_full;

    assign word_full  = (cnt_q == CNT_W'(WORD_W - 1));
    assign rb_data_o  = rb_data_q;
    assign rb_valid_o = rb_valid_q;

    // Insert the sampled bit at the next MSB-first position and decide on emission
    always_comb begin
        idx        = CNT_W'(WORD_W - 1) - cnt_q;
        col_ins    = col_q;
        col_ins[idx] = bit_i;
        col_d      = col_q;
        cnt_d      = cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (clear_i) begin
            col_d = '0;
            cnt_d = '0;
        end else if (sample_i) begin
            if (word_full || last_i) begin
                // Remaining LSBs of col_ins are still zero from the last clear
                rb_data_d  = col_ins;
                rb_valid_d = 1'b1;
                col_d      = '0;
                cnt_d      = '0;
            end else begin
                col_d = col_ins;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Collector and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q      <= '0;
            cnt_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration chain loader: accepts bitstream words, shifts them MSB first
// into a fabric ccff chain, collects the chain tail for readback, and
// controls fabric isolation around the programming sequence.
`timescale 1ns/1ps

module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN   = 1024,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [WORD_W-1:0]              cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic [WORD_W-1:0]              rb_data,
    output logic                           rb_valid,
    output logic                           isol_n,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

    localparam int BC_W = $clog2(CHAIN_LEN + 1);
    localparam int N_W  = $clog2(WORD_W + 1);
    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_e            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [N_W-1:0]    n_q, n_d, n_load;
    logic [SC_W-1:0]   settle_q, settle_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic [31:0]       remain;
    logic              in_load, in_shift, in_settle, idle_like;
    logic              can_start, hs, last_bit;

    assign in_load   = (state_q == ST_LOAD);
    assign in_shift  = (state_q == ST_SHIFT);
    assign in_settle = (state_q == ST_SETTLE);
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign can_start = start && idle_like;

    // Abort wins over a handshake, so ready is withdrawn while abort is high
    assign cfg_ready = in_load && !abort;
    assign hs        = cfg_valid && cfg_ready;

    // Bits still owed to the chain; a short final word uses only its upper bits
    assign remain = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
    assign n_load = (remain > 32'(WORD_W)) ? N_W'(WORD_W) : N_W'(remain);
    assign last_bit = (bit_cnt_q == BC_W'(CHAIN_LEN - 1));

    assign ccff_shift_en = in_shift;
    assign ccff_head     = in_shift && shreg_q[WORD_W-1];
    assign isol_n        = (state_q == ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign err           = (state_q == ST_ERR);
    assign busy          = in_load || in_shift || in_settle;
    assign bit_count     = bit_cnt_q;

    // Next-state and datapath update for the programming sequence
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        n_d       = n_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_ERR;
                end else if (hs) begin
                    shreg_d = cfg_data;
                    n_d     = n_load;
                    tmo_d   = '0;
                    state_d = ST_SHIFT;
                end else if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // The fabric shifts this cycle regardless of abort, so count it
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                n_d       = n_q - 1'b1;
                if (abort) begin
                    state_d = ST_ERR;
                end else if (n_q == N_W'(1)) begin
                    if (last_bit) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end else begin
                        state_d = ST_LOAD;
                        tmo_d   = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_ERR;
                end else if (settle_q == SC_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            n_q       <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            n_q       <= n_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
        end
    end

    ccff_rb_collector #(
        .WORD_W (WORD_W)
    ) u_rb (
        .clk_i      (prog_clk),
        .rst_ni     (prog_reset),
        .clear_i    (can_start),
        .sample_i   (in_shift),
        .bit_i      (ccff_tail),
        .last_i     (last_bit),
        .rb_data_o  (rb_data),
        .rb_valid_o (rb_valid)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 40-bit chain model.
`timescale 1ns/1ps

module tb_ccff_chain_loader;

    logic        clk;
    logic        prog_reset;
    logic        start, abort;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic [31:0] rb_data;
    logic        rb_valid, isol_n, busy, done, err;
    logic [5:0]  bit_count;

    logic        start_b, abort_b, cfg_valid_b, tail_b;
    logic [31:0] cfg_data_b;
    logic        cfg_ready_b, head_b, shift_en_b;
    logic [31:0] rb_data_b;
    logic        rb_valid_b, isol_n_b, busy_b, done_b, err_b;
    logic [5:0]  bit_count_b;

    logic [39:0] model;
    logic [39:0] preload_val;
    logic        preload_req;
    int          shift_total;
    int          rb_n;
    logic [31:0] rb_log [16];
    int          rb_at  [16];

    int checks = 0;
    int errors = 0;

    ccff_chain_loader #(
        .CHAIN_LEN(40), .WORD_W(32), .SETTLE_CYC(4), .TIMEOUT_CYC(4096)
    ) dut (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .rb_data(rb_data), .rb_valid(rb_valid), .isol_n(isol_n), .busy(busy),
        .done(done), .err(err), .bit_count(bit_count)
    );

    ccff_chain_loader #(
        .CHAIN_LEN(40), .WORD_W(32), .SETTLE_CYC(4), .TIMEOUT_CYC(8)
    ) dut_to (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start_b), .abort(abort_b),
        .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .ccff_head(head_b), .ccff_shift_en(shift_en_b), .ccff_tail(tail_b),
        .rb_data(rb_data_b), .rb_valid(rb_valid_b), .isol_n(isol_n_b), .busy(busy_b),
        .done(done_b), .err(err_b), .bit_count(bit_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ccff_tail = model[39];

    // Fabric chain model plus shift and readback monitors
    always @(posedge clk) begin
        if (preload_req) model <= preload_val;
        else if (ccff_shift_en) model <= {model[38:0], ccff_head};
        if (ccff_shift_en) shift_total <= shift_total + 1;
        if (rb_valid) begin
            rb_log[rb_n % 16] <= rb_data;
            rb_at[rb_n % 16]  <= shift_total;
            rb_n              <= rb_n + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int waited;
        waited    = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (!cfg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word_ready: cfg_ready=%b, expected 1 within 200 cycles", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(output int since, output bit ok);
        since = 0;
        ok    = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (ccff_shift_en) since = 0;
            else since++;
            @(negedge clk);
        end
    endtask

    task automatic do_preload(input logic [39:0] v);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({isol_n, cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 00000000",
                     {isol_n, cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, err});
        end
        checks++;
        if (bit_count !== 6'd0 || rb_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: bit_count=%0d rb_data=%h, expected 0 and 0", bit_count, rb_data);
        end
        prog_reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ccff_shift_en !== 1'b0 || busy !== 1'b0 || shift_total != 0) begin
            errors++;
            $display("FAIL post_reset_idle: shift_en=%b busy=%b shifts=%0d, expected 0 0 0",
                     ccff_shift_en, busy, shift_total);
        end
    endtask

    task automatic test_full_load();
        int base, since;
        bit ok;
        base = shift_total;
        do_start();
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || isol_n !== 1'b0 || bit_count !== 6'd0) begin
            errors++;
            $display("FAIL start_to_load: busy=%b ready=%b isol_n=%b bit_count=%0d, expected 1 1 0 0",
                     busy, cfg_ready, isol_n, bit_count);
        end
        send_word(32'hDEADBEEF);
        send_word(32'hA5000000);
        wait_done(since, ok);
        checks++;
        if (!ok || done !== 1'b1 || isol_n !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done=%b isol_n=%b err=%b, expected 1 1 0", done, isol_n, err);
        end
        checks++;
        if (shift_total - base != 40) begin
            errors++;
            $display("FAIL full_shift_count: got %0d, expected 40", shift_total - base);
        end
        checks++;
        if (model !== 40'hDEADBEEF_A5) begin
            errors++;
            $display("FAIL full_chain: got %h, expected deadbeefa5", model);
        end
        checks++;
        if (since != 4) begin
            errors++;
            $display("FAIL settle_len: got %0d idle cycles before release, expected 4", since);
        end
        checks++;
        if (bit_count !== 6'd40 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_status: bit_count=%0d busy=%b, expected 40 0", bit_count, busy);
        end
        // abort while DONE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || isol_n !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_done: done=%b err=%b isol_n=%b, expected 1 0 1", done, err, isol_n);
        end
    endtask

    task automatic test_readback();
        int base, rbase, since;
        bit ok;
        do_preload(40'h12345678_9A);
        base  = shift_total;
        rbase = rb_n;
        do_start();
        checks++;
        if (done !== 1'b0 || isol_n !== 1'b0) begin
            errors++;
            $display("FAIL restart_clears_done: done=%b isol_n=%b, expected 0 0", done, isol_n);
        end
        send_word(32'hDEADBEEF);
        send_word(32'hA5000000);
        wait_done(since, ok);
        checks++;
        if (rb_n - rbase != 2) begin
            errors++;
            $display("FAIL rb_count: got %0d pulse cycles, expected 2", rb_n - rbase);
        end
        checks++;
        if (rb_log[rbase % 16] !== 32'h12345678 || rb_at[rbase % 16] - base != 32) begin
            errors++;
            $display("FAIL rb_word0: data=%h at shift %0d, expected 12345678 at 32",
                     rb_log[rbase % 16], rb_at[rbase % 16] - base);
        end
        checks++;
        if (rb_log[(rbase + 1) % 16] !== 32'h9A000000 || rb_at[(rbase + 1) % 16] - base != 40) begin
            errors++;
            $display("FAIL rb_word1: data=%h at shift %0d, expected 9a000000 at 40",
                     rb_log[(rbase + 1) % 16], rb_at[(rbase + 1) % 16] - base);
        end
        checks++;
        if (!ok || model !== 40'hDEADBEEF_A5) begin
            errors++;
            $display("FAIL rb_chain: done=%b chain=%h, expected 1 deadbeefa5", ok, model);
        end
    endtask

    task automatic test_backpressure();
        int base, since, bad;
        bit ok;
        do_preload(40'h0);
        base = shift_total;
        do_start();
        send_word(32'hDEADBEEF);
        for (int i = 0; i < 100 && cfg_ready !== 1'b1; i++) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ccff_shift_en !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || shift_total - base != 32) begin
            errors++;
            $display("FAIL gap_idle: %0d bad gap cycles, shifts=%0d, expected 0 and 32",
                     bad, shift_total - base);
        end
        send_word(32'hA5000000);
        wait_done(since, ok);
        checks++;
        if (!ok || model !== 40'hDEADBEEF_A5 || shift_total - base != 40) begin
            errors++;
            $display("FAIL bp_chain: done=%b chain=%h shifts=%0d, expected 1 deadbeefa5 40",
                     ok, model, shift_total - base);
        end
    endtask

    task automatic test_abort();
        int since;
        bit ok;
        logic [5:0] held;
        do_start();
        cfg_data  = 32'hDEADBEEF;
        cfg_valid = 1'b1;
        for (int i = 0; i < 100 && !(bit_count == 6'd20 && ccff_shift_en); i++) begin
            @(negedge clk);
            if (ccff_shift_en) cfg_valid = 1'b0;
        end
        cfg_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (err !== 1'b1 || isol_n !== 1'b0 || busy !== 1'b0 || ccff_shift_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_err: err=%b isol_n=%b busy=%b shift_en=%b, expected 1 0 0 0",
                     err, isol_n, busy, ccff_shift_en);
        end
        checks++;
        if (bit_count !== 6'd20 && bit_count !== 6'd21) begin
            errors++;
            $display("FAIL abort_count: got %0d, expected 20 or 21", bit_count);
        end
        held = bit_count;
        repeat (3) @(negedge clk);
        checks++;
        if (bit_count !== held || err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: bit_count=%0d err=%b, expected %0d 1", bit_count, err, held);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || bit_count !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_err: err=%b bit_count=%0d busy=%b, expected 0 0 1",
                     err, bit_count, busy);
        end
        send_word(32'h0F0F1234);
        send_word(32'hC3FFFFFF);
        wait_done(since, ok);
        checks++;
        if (!ok || model !== 40'h0F0F1234_C3) begin
            errors++;
            $display("FAIL reload_chain: done=%b chain=%h, expected 1 0f0f1234c3", ok, model);
        end
    endtask

    task automatic test_timeout();
        int bad;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            if (busy_b !== 1'b1 || err_b !== 1'b0 || shift_en_b !== 1'b0) bad++;
            if (i == 3) start_b = 1'b1;
            if (i == 4) start_b = 1'b0;
            if (i < 8) @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_wait: %0d bad LOAD cycles, expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if (err_b !== 1'b1 || isol_n_b !== 1'b0 || busy_b !== 1'b0 || bit_count_b !== 6'd0) begin
            errors++;
            $display("FAIL timeout_err: err=%b isol_n=%b busy=%b bit_count=%0d, expected 1 0 0 0",
                     err_b, isol_n_b, busy_b, bit_count_b);
        end
    endtask

    task automatic test_reset_mid_shift();
        do_start();
        send_word(32'hFFFFFFFF);
        repeat (5) @(negedge clk);
        #2 prog_reset = 1'b0;
        #1;
        checks++;
        if ({isol_n, cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, err} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_flags: got %b, expected 00000000",
                     {isol_n, cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done, err});
        end
        checks++;
        if (bit_count !== 6'd0 || rb_data !== 32'h0 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL midreset_data: bit_count=%0d rb_data=%h err_b=%b, expected 0 0 0",
                     bit_count, rb_data, err_b);
        end
        @(negedge clk);
        prog_reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ccff_shift_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: shift_en=%b busy=%b ready=%b, expected 0 0 0",
                     ccff_shift_en, busy, cfg_ready);
        end
    endtask

    initial begin
        prog_reset  = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_data    = 32'h0;
        cfg_valid   = 1'b0;
        start_b     = 1'b0;
        abort_b     = 1'b0;
        cfg_data_b  = 32'h0;
        cfg_valid_b = 1'b0;
        tail_b      = 1'b0;
        preload_req = 1'b0;
        preload_val = 40'h0;
        model       = 40'h0;
        shift_total = 0;
        rb_n        = 0;
        @(negedge clk);
        test_reset();
        test_full_load();
        test_readback();
        test_backpressure();
        test_abort();
        test_timeout();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameters SHALL be exactly the following, one per line:
- CHAIN_LEN, default 1024, total configuration bits in the target ccff chain, minimum 1.
- WORD_W, default 32, width of a bitstream word.
- SETTLE_CYC, default 4, idle prog_clk cycles between the last shift and isolation release, minimum 1.
- TIMEOUT_CYC, default 4096, maximum number of cycles spent waiting for a word in LOAD.
REQ-002 Ports SHALL be exactly the following, one per line:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin programming.
- abort  in  1  cancel any operation in progress.
- cfg_data  in  WORD_W  bitstream word, MSB shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  block accepts cfg_data this cycle.
- ccff_head  out  1  serial data into the fabric chain.
- ccff_shift_en  out  1  clock-enable for the fabric prog_clk gate.
- ccff_tail  in  1  serial data out of the chain (readback).
- rb_data  out  WORD_W  assembled readback word.
- rb_valid  out  1  one-cycle pulse, rb_data is valid.
- isol_n  out  1  fabric isolation; 0 means isolated.
- busy  out  1  state is not IDLE, DONE or ERR.
- done  out  1  chain fully programmed and released.
- err  out  1  aborted or timed out.
- bit_count  out  clog2(CHAIN_LEN+1)  bits shifted so far.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, SHIFT, SETTLE, DONE and ERR.
REQ-004 start in IDLE, DONE or ERR SHALL move to LOAD next cycle, clear bit_count, done and err, and drive isol_n=0; start in any other state SHALL be ignored.
REQ-005 In LOAD, cfg_ready SHALL be 1; a handshake (cfg_valid and cfg_ready) SHALL latch cfg_data into the shift register, load n = min(WORD_W, CHAIN_LEN - bit_count), and enter SHIFT.
REQ-006 In SHIFT, each cycle SHALL drive ccff_head = shreg[WORD_W-1] and ccff_shift_en=1, shift shreg left by one, increment bit_count and decrement n.
REQ-007 When the cycle with n==1 completes, the FSM SHALL enter SETTLE if bit_count reaches CHAIN_LEN, otherwise LOAD; a partial final word SHALL use its upper n bits and discard the rest.
REQ-008 Outside SHIFT, ccff_shift_en SHALL be 0 and ccff_head SHALL be 0.
REQ-009 Readback:
- On every SHIFT cycle, ccff_tail SHALL be sampled into a WORD_W collector, MSB first.
- When WORD_W bits have been collected, or at the final chain bit with zero-padded LSBs, rb_data SHALL update and rb_valid SHALL pulse for one cycle.
- rb_valid has no backpressure.
REQ-010 SETTLE SHALL last exactly SETTLE_CYC cycles and then enter DONE.
REQ-011 In DONE, isol_n SHALL be 1 and done SHALL be 1, held until the next start.
REQ-012 Timeout: if LOAD waits TIMEOUT_CYC consecutive cycles without a handshake, the FSM SHALL enter ERR.
REQ-013 abort in LOAD, SHIFT or SETTLE SHALL enter ERR next cycle, with priority over a simultaneous handshake or shift completion; abort in IDLE, DONE or ERR SHALL have no effect.
REQ-014 In ERR, err SHALL be 1, isol_n SHALL be 0, and bit_count SHALL hold its value at entry.
REQ-015 In any state other than DONE, isol_n SHALL be 0.
REQ-016 busy SHALL be 1 exactly in LOAD, SHIFT and SETTLE.
REQ-017 Programming throughput SHALL be one bit per cycle within a word, plus a minimum of one LOAD cycle per word.

Reset
REQ-018 prog_reset low SHALL asynchronously force:
- state to IDLE;
- isol_n, cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done and err to 0;
- bit_count, rb_data, the shift register and all counters to 0.
REQ-019 Deassertion of prog_reset SHALL be followed by no shift activity until a start is received.

Structure
REQ-020 A shared package ccff_loader_pkg SHALL hold the state enum and the default WORD_W.
REQ-021 The readback collector SHALL be a sub-module ccff_rb_collector; all other logic SHALL be flat.

Verification
Benches use CHAIN_LEN=40, WORD_W=32, SETTLE_CYC=4 and a 40-bit shift-register model of the chain.
REQ-022 Full load: start, then words 0xDEADBEEF and 0xA5000000 -> exactly 40 ccff_shift_en cycles; model holds DEADBEEF followed by A5; isol_n rises 4 cycles after the last shift; done=1.
REQ-023 Readback: model preloaded with 0x12345678_9A -> rb_data=0x12345678 pulses after 32 shifts, then rb_data=0x9A000000 after 40 shifts.
REQ-024 Backpressure: cfg_valid withheld 10 cycles between the two words -> ccff_shift_en=0 during the gap; final chain content is unchanged from REQ-022.
REQ-025 Abort on shift 20 -> err=1 next cycle, bit_count=20 (or 21 if that shift completed), isol_n=0; a following start completes a normal load.
REQ-026 Timeout: with TIMEOUT_CYC=8 and no cfg_valid after start -> err=1 after 8 LOAD cycles; start during a busy load is ignored.
REQ-027 Reset mid-shift: prog_reset pulsed low -> all outputs 0 immediately and state IDLE.
